prog_freq_divider: RTL
======================

// Module: prog_freq_divider
// PURPOSE
//   Runtime-programmable integer clock divider, successor to the fixed divide-by-2 cell.
//   Divides clk by R (1..2^WIDTH-1) into registered q_out (near-50% duty) plus a 1-cycle tick (clock enable).
//   Ratio changes are glitch-free: a new ratio takes effect only at an output period boundary.
//   Sits between the system clock and slow peripherals (baud/PWM/scan timing); q_out is data, never used as a clock.
// PARAMETERS
//   WIDTH        8   width of ratio and phase counter
//   RESET_RATIO  2   active ratio after reset; must be < 2^WIDTH (2 = legacy divide-by-2)
//   CNT_W        16  width of period_cnt (only with FREQ_DIV_PERIOD_CNT_EN)
// PORTS
//   clk         in   1      single clock, all flops rising-edge
//   reset_n     in   1      synchronous reset, active-low
//   en          in   1      count enable; 0 freezes phase
//   load        in   1      1-cycle strobe: capture div_ratio into shadow
//   div_ratio   in   WIDTH  requested ratio R; 0 = stop
//   q_out       out  1      divided output, registered
//   tick        out  1      1-cycle pulse on first cycle of each output period, registered
//   pending     out  1      shadow ratio captured, not yet applied
//   period_cnt  out  CNT_W  completed-period counter (FREQ_DIV_PERIOD_CNT_EN only)
// BEHAVIOUR
//   - Reset (reset_n=0 at edge): phase=RESET_RATIO-1, active=RESET_RATIO, shadow=0, q_out=0, tick=0, pending=0, period_cnt=0.
//   - Phase p counts 0..R-1 on enabled edges; wrap R-1 -> 0 is a period boundary.
//   - H = R - floor(R/2) (ceil R/2); q_out=1 for p<H, else 0. Odd R: high one cycle longer.
//   - Registered outputs: edge that moves p to p_next loads q_out<=(p_next<H), tick<=(p_next==0).
//   - First enabled edge after reset starts a period: tick=1, q_out=1.
//   - R=1: every edge is a boundary; q_out constant 1, tick=1 every enabled cycle.
//   - R=0 (stopped): q_out<=0, tick<=0, phase held at 0; every edge counts as a boundary for ratio apply.
//   - en=0: phase and q_out hold; tick<=0. Resume continues from held phase, no extra tick.
//   - load=1: shadow<=div_ratio, pending<=1, regardless of en. Load while pending: last wins.
//   - Apply: at the next boundary edge strictly after the load edge, active<=shadow, pending<=0,
//     and that edge starts the new period (p_next=0, tick=1 unless new R=0).
//     Load coinciding with a boundary is applied at the following boundary.
//   - Leaving stop: load of R>0 while stopped -> applied on the next edge (tick=1, q_out=1).
//   - en=0 with pending: apply waits for the next enabled boundary; stop state applies regardless of en.
//   - Reset mid-operation overrides load/en; shadow lost, outputs as above from the next edge.
//   - No combinational path from any input to any output.
// CONFIGURATION
//   FREQ_DIV_PERIOD_CNT_EN defined: period_cnt port present; +1 (mod 2^CNT_W) on every edge that sets tick=1.
//   Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package freq_div_pkg: RATIO_STOP=0, DEFAULT_WIDTH=8, function high_len(ratio) returning ceil(R/2).
//   Sub-module freq_div_phase_ctr: phase counter + q_out/tick decode for a given active ratio;
//   the top holds shadow/pending/apply logic and the optional period counter.
// TESTING
//   1. Reset, en=1, defaults -> q_out 1,0,1,0..., tick 1,0,1,0..., pending=0.
//   2. R=2 running, load div_ratio=5 mid-period -> pending=1 until boundary; then q_out 1,1,1,0,0 repeating, tick every 5th cycle.
//   3. Load 1 -> q_out constant 1, tick every cycle; load 0 -> q_out=0, tick=0; load 3 -> next edge tick=1, q_out 1,1,0.
//   4. R=4, en=0 for 3 cycles at p=1 -> q_out held 1, tick 0; resume -> p 2,3,0 with q_out 0,0,1, single tick at p=0.
//   5. Two loads (6 then 7) before boundary -> 7 applied, pending cleared at that boundary; load on boundary edge applies one period later.
//   6. reset_n low mid-period with pending=1 -> next edge q_out=0, tick=0, pending=0, period_cnt=0 (PERIOD_CNT_EN build: count of ticks matches in both builds otherwise).

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable frequency divider.
package freq_div_pkg;

  // A ratio of zero stops the divider.
  localparam int unsigned RATIO_STOP    = 0;
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Number of high cycles per period: ceil(R/2), so odd ratios are high one cycle longer.
  function automatic int unsigned high_len(input int unsigned ratio);
    return ratio - (ratio / 2);
  endfunction

endpackage

// File: rtl/freq_div_phase_ctr.sv
// Phase counter and registered q/tick decode for the currently active ratio.
// A restart forces the next edge to begin a fresh period using the newly applied ratio.
module freq_div_phase_ctr
  import freq_div_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PHASE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_ratio,
  input  logic             i_restart,
  input  logic [WIDTH-1:0] i_new_ratio,
  output logic             o_boundary,
  output logic             o_tick_next,
  output logic             o_q,
  output logic             o_tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_phase;
  logic             r_q;
  logic             r_tick;
  logic [WIDTH-1:0] w_phase_next;
  logic [WIDTH-1:0] w_high;
  logic             w_q_next;
  logic             w_stopped;
  logic             w_wrap;

  assign w_stopped  = (i_ratio == WIDTH'(RATIO_STOP));
  assign w_wrap     = i_en && !w_stopped && (r_phase == (i_ratio - ONE));
  // A stopped divider treats every edge as a boundary so a new ratio can be applied at once.
  assign o_boundary = w_stopped || w_wrap;
  assign w_high     = WIDTH'(high_len(32'(i_ratio)));

  assign o_q    = r_q;
  assign o_tick = r_tick;

  // Next phase and next q/tick values for the coming edge.
  always_comb begin
    w_phase_next = r_phase;
    w_q_next     = r_q;
    o_tick_next  = 1'b0;
    if (i_restart) begin
      w_phase_next = '0;
      w_q_next     = (i_new_ratio != WIDTH'(RATIO_STOP));
      o_tick_next  = w_q_next;
    end else if (w_stopped) begin
      w_phase_next = '0;
      w_q_next     = 1'b0;
    end else if (i_en) begin
      w_phase_next = w_wrap ? '0 : (r_phase + ONE);
      w_q_next     = (w_phase_next < w_high);
      o_tick_next  = w_wrap;
    end
  end

  // Phase and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_phase <= RESET_PHASE;
      r_q     <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_phase <= w_phase_next;
      r_q     <= w_q_next;
      r_tick  <= o_tick_next;
    end
  end

endmodule

// File: rtl/prog_freq_divider.sv
// Runtime-programmable integer divider: registered q_out (near-50% duty) and a 1-cycle tick.
// New ratios are staged in a shadow register and only take effect at a period boundary.
// Optional completed-period counter enabled by defining FREQ_DIV_PERIOD_CNT_EN.
module prog_freq_divider
  import freq_div_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned RESET_RATIO = 2
`ifdef FREQ_DIV_PERIOD_CNT_EN
  ,
  parameter int unsigned CNT_W       = 16
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div_ratio,
  output logic             o_q_out,
  output logic             o_tick,
  output logic             o_pending
`ifdef FREQ_DIV_PERIOD_CNT_EN
  ,
  output logic [CNT_W-1:0] o_period_cnt
`endif
);

  localparam logic [WIDTH-1:0] RESET_ACTIVE = WIDTH'(RESET_RATIO);
  // Start one step before the wrap so the first enabled edge opens a period.
  localparam logic [WIDTH-1:0] RESET_PHASE  =
      (RESET_RATIO == 0) ? '0 : WIDTH'(RESET_RATIO - 1);

  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_shadow;
  logic             r_pending;
  logic             w_boundary;
  logic             w_apply;
  logic             w_tick_next;

  // A load on the boundary edge itself waits for the following boundary.
  assign w_apply   = r_pending && w_boundary && !i_load;
  assign o_pending = r_pending;

  freq_div_phase_ctr #(
    .WIDTH       (WIDTH),
    .RESET_PHASE (RESET_PHASE)
  ) u_phase_ctr (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_en        (i_en),
    .i_ratio     (r_active),
    .i_restart   (w_apply),
    .i_new_ratio (r_shadow),
    .o_boundary  (w_boundary),
    .o_tick_next (w_tick_next),
    .o_q         (o_q_out),
    .o_tick      (o_tick)
  );

  // Shadow capture and boundary-aligned ratio apply; last load before the boundary wins.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_active  <= RESET_ACTIVE;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_apply) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
      if (i_load) begin
        r_shadow  <= i_div_ratio;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef FREQ_DIV_PERIOD_CNT_EN
  logic [CNT_W-1:0] r_period_cnt;

  assign o_period_cnt = r_period_cnt;

  // Count every edge that raises tick, so the counter moves together with tick.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_period_cnt <= '0;
    end else if (w_tick_next) begin
      r_period_cnt <= r_period_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
